// File: rtl/spram_arb_pkg.sv
// Shared widths and arbiter state encoding for the SPRAM frame-buffer arbiter.
package spram_arb_pkg;

    localparam int SPRAM_ADDR_W = 15;
    localparam int PIX_W        = 12;
    localparam int COORD_W      = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/spram_arb_fifo.sv
// Synchronous write FIFO for incoming pixels. Flush empties the queue; a push
// in the same cycle as a flush lands as the first entry of the fresh queue.
// A push while full is accepted only when a pop happens in the same cycle.
module spram_arb_fifo
    import spram_arb_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = PIX_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign push_ok = push && (flush || !full || pop);
    assign pop_ok  = pop && !empty && !flush;

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= AW'(push_ok);
            rd_ptr <= '0;
            count  <= CNT_W'(push_ok);
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

    // Storage array; contents need no reset because occupancy gates all reads
    always_ff @(posedge clk) begin
        if (push_ok) mem[flush ? '0 : wr_ptr] <= push_data;
    end

endmodule

// File: rtl/spram_arbiter.sv
// Single-port RAM arbiter between a raster-order pixel writer (buffered in a
// small FIFO) and a never-stalling VGA pixel reader. Reads always win.
// Optional statistics counters are built when SPRAM_ARB_STATS_EN is defined.
//
// state | meaning
// IDLE  | no SPRAM access this cycle (also used for discarded pixels)
// WRITE | SPRAM write of the FIFO head at o_pix_cnt
// READ  | SPRAM read address driven for a pixel fetch
module spram_arbiter
    import spram_arb_pkg::*;
#(
    parameter int IMG_W       = 160,
    parameter int IMG_H       = 120,
    parameter int WFIFO_DEPTH = 8
) (
    input  logic                    i_clk_sys,
    input  logic                    i_rst_n,
    input  logic                    i_frame_start,
    input  logic                    i_wr_valid,
    input  logic [PIX_W-1:0]        i_wr_data,
    output logic                    o_wr_ready,
    input  logic                    i_rd_req,
    input  logic [COORD_W-1:0]      i_rd_x,
    input  logic [COORD_W-1:0]      i_rd_y,
    output logic                    o_rd_valid,
    output logic [PIX_W-1:0]        o_rd_data,
    output logic [SPRAM_ADDR_W-1:0] o_spram_addr,
    output logic [PIX_W-1:0]        o_spram_wr_data,
    output logic                    o_spram_wre,
    input  logic [PIX_W-1:0]        i_spram_rd_data,
    output logic [SPRAM_ADDR_W-1:0] o_pix_cnt,
    output logic                    o_image_complete
`ifdef SPRAM_ARB_STATS_EN
    ,
    output logic [15:0]             o_stall_cnt,
    output logic [7:0]              o_ovf_cnt
`endif
);

    localparam int CNT_W = $clog2(WFIFO_DEPTH) + 1;
    localparam logic [SPRAM_ADDR_W-1:0] PIX_LAST = SPRAM_ADDR_W'(IMG_W * IMG_H - 1);

    arb_state_t              state;
    logic                    push;
    logic                    pop;
    logic [PIX_W-1:0]        fifo_head;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [CNT_W-1:0]        fifo_count;
    logic [SPRAM_ADDR_W-1:0] rd_addr;
    logic                    rd_oob;
    logic                    rd_oob_s1;
    logic                    rd_oob_s2;
    logic                    done;

    // Ready comes from the registered occupancy, so a same-cycle pop never frees a slot early.
    assign o_wr_ready = (fifo_count != CNT_W'(WFIFO_DEPTH));
    assign push       = i_wr_valid && !fifo_full;
    assign pop        = !i_frame_start && !i_rd_req && !fifo_empty;

    assign rd_addr = SPRAM_ADDR_W'(20'(i_rd_y) * 20'(IMG_W) + 20'(i_rd_x));
    assign rd_oob  = (int'(i_rd_x) >= IMG_W) || (int'(i_rd_y) >= IMG_H);

    // SPRAM data arrives one cycle after the address, alongside o_rd_valid.
    assign o_rd_data = (o_rd_valid && !rd_oob_s2) ? i_spram_rd_data : '0;

    spram_arb_fifo #(
        .DEPTH (WFIFO_DEPTH),
        .WIDTH (PIX_W)
    ) u_fifo (
        .clk       (i_clk_sys),
        .rst_n     (i_rst_n),
        .flush     (i_frame_start),
        .push      (push),
        .push_data (i_wr_data),
        .pop       (pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Arbitration FSM with registered SPRAM port, read pipeline and pixel counter
    always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state            <= IDLE;
            o_spram_addr     <= '0;
            o_spram_wr_data  <= '0;
            o_spram_wre      <= 1'b0;
            o_pix_cnt        <= '0;
            o_image_complete <= 1'b0;
            o_rd_valid       <= 1'b0;
            rd_oob_s1        <= 1'b0;
            rd_oob_s2        <= 1'b0;
            done             <= 1'b0;
        end else begin
            state            <= IDLE;
            o_spram_wre      <= 1'b0;
            o_image_complete <= 1'b0;
            o_rd_valid       <= (state == READ);
            rd_oob_s2        <= rd_oob_s1;
            rd_oob_s1        <= rd_oob;

            if (i_rd_req) begin
                state <= READ;
                // Out-of-range fetches leave the address bus untouched.
                if (!rd_oob) o_spram_addr <= rd_addr;
            end else if (pop && !done) begin
                state           <= WRITE;
                o_spram_wre     <= 1'b1;
                o_spram_addr    <= o_pix_cnt;
                o_spram_wr_data <= fifo_head;
                o_pix_cnt       <= o_pix_cnt + SPRAM_ADDR_W'(1);
                if (o_pix_cnt == PIX_LAST) begin
                    done             <= 1'b1;
                    o_image_complete <= 1'b1;
                end
            end

            if (i_frame_start) begin
                o_pix_cnt <= '0;
                done      <= 1'b0;
            end
        end
    end

`ifdef SPRAM_ARB_STATS_EN
    // Saturating stall/overflow statistics, cleared at every frame start
    always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_stall_cnt <= '0;
            o_ovf_cnt   <= '0;
        end else if (i_frame_start) begin
            o_stall_cnt <= '0;
            o_ovf_cnt   <= '0;
        end else begin
            if (i_rd_req && !fifo_empty && o_stall_cnt != 16'hFFFF)
                o_stall_cnt <= o_stall_cnt + 16'd1;
            if (i_wr_valid && !o_wr_ready && o_ovf_cnt != 8'hFF)
                o_ovf_cnt <= o_ovf_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_spram_arbiter.sv
// Directed self-checking bench for spram_arbiter (default 160x120 image).
module tb_spram_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        frame_start;
    logic        wr_valid;
    logic [11:0] wr_data;
    logic        wr_ready;
    logic        rd_req;
    logic [9:0]  rd_x;
    logic [9:0]  rd_y;
    logic        rd_valid;
    logic [11:0] rd_data;
    logic [14:0] spram_addr;
    logic [11:0] spram_wr_data;
    logic        spram_wre;
    logic [11:0] spram_rd_data;
    logic [14:0] pix_cnt;
    logic        image_complete;
`ifdef SPRAM_ARB_STATS_EN
    logic [15:0] stall_cnt;
    logic [7:0]  ovf_cnt;
`endif

    typedef struct packed {
        logic [14:0] a;
        logic [11:0] d;
    } wr_t;

    wr_t         wlog[$];
    int          n_cmpl = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    logic [11:0] pix4 [4] = '{12'h00F, 12'h0F0, 12'hF00, 12'hFFF};

    spram_arbiter dut (
        .i_clk_sys        (clk),
        .i_rst_n          (rst_n),
        .i_frame_start    (frame_start),
        .i_wr_valid       (wr_valid),
        .i_wr_data        (wr_data),
        .o_wr_ready       (wr_ready),
        .i_rd_req         (rd_req),
        .i_rd_x           (rd_x),
        .i_rd_y           (rd_y),
        .o_rd_valid       (rd_valid),
        .o_rd_data        (rd_data),
        .o_spram_addr     (spram_addr),
        .o_spram_wr_data  (spram_wr_data),
        .o_spram_wre      (spram_wre),
        .i_spram_rd_data  (spram_rd_data),
        .o_pix_cnt        (pix_cnt),
        .o_image_complete (image_complete)
`ifdef SPRAM_ARB_STATS_EN
        ,
        .o_stall_cnt      (stall_cnt),
        .o_ovf_cnt        (ovf_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Record every committed SPRAM write and every completion pulse cycle
    always @(posedge clk) begin
        if (spram_wre) wlog.push_back({spram_addr, spram_wr_data});
        if (image_complete) n_cmpl++;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_values(input string pfx);
        chk({pfx, "_pix_cnt"},  32'(pix_cnt), 0);
        chk({pfx, "_addr"},     32'(spram_addr), 0);
        chk({pfx, "_wr_data"},  32'(spram_wr_data), 0);
        chk({pfx, "_wre"},      32'(spram_wre), 0);
        chk({pfx, "_rd_valid"}, 32'(rd_valid), 0);
        chk({pfx, "_rd_data"},  32'(rd_data), 0);
        chk({pfx, "_complete"}, 32'(image_complete), 0);
        chk({pfx, "_wr_ready"}, 32'(wr_ready), 1);
    endtask

    initial begin
        int  base;
        int  c0;
        int  idx;
        int  cyc;
        logic acc;
        logic seen;

        rst_n = 1'b0; frame_start = 1'b0; wr_valid = 1'b0; wr_data = '0;
        rd_req = 1'b0; rd_x = '0; rd_y = '0; spram_rd_data = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_values("rst");
        rst_n = 1'b1;
        tick();

        // Write path: four pixels land at addresses 0..3 in order
        base = wlog.size();
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wr_valid = 1'b1; wr_data = pix4[i]; tick();
        end
        wr_valid = 1'b0;
        repeat (4) tick();
        chk("wp_nwr", wlog.size() - base, 4);
        for (int i = 0; i < 4; i++) begin
            chk("wp_addr", 32'(wlog[base+i].a), i);
            chk("wp_data", 32'(wlog[base+i].d), 32'(pix4[i]));
        end
        chk("wp_pix_cnt", 32'(pix_cnt), 4);

        // Read latency: (5,2) -> address 325 at N+1, data at N+2
        spram_rd_data = 12'hABC;
        rd_req = 1'b1; rd_x = 10'd5; rd_y = 10'd2; tick(); rd_req = 1'b0;
        chk("rl_addr", 32'(spram_addr), 325);
        chk("rl_valid_n1", 32'(rd_valid), 0);
        tick();
        chk("rl_valid_n2", 32'(rd_valid), 1);
        chk("rl_data", 32'(rd_data), 32'h ABC);
        tick();
        chk("rl_valid_n3", 32'(rd_valid), 0);

        // Out of bounds: x=160 gives zero data and no address change
        rd_req = 1'b1; rd_x = 10'd160; rd_y = 10'd0; tick(); rd_req = 1'b0;
        chk("oob_addr", 32'(spram_addr), 325);
        tick();
        chk("oob_valid", 32'(rd_valid), 1);
        chk("oob_data", 32'(rd_data), 0);

        // Read priority: continuous reads block writes while the FIFO fills
        base = wlog.size();
        rd_req = 1'b1; rd_x = 10'd3; rd_y = 10'd1;
        for (int i = 0; i < 10; i++) begin
            wr_valid = 1'b1;
            wr_data  = (i < 8) ? 12'(12'h100 + i) : 12'hEEE;
            tick();
            if (i > 0) chk("rp_valid", 32'(rd_valid), 1);
        end
        chk("rp_ready", 32'(wr_ready), 0);
        chk("rp_no_write", wlog.size() - base, 0);
        rd_req = 1'b0; wr_valid = 1'b0;
        repeat (12) tick();
        chk("rp_nwr", wlog.size() - base, 8);
        chk("rp_first_addr", 32'(wlog[base].a), 4);
        chk("rp_first_data", 32'(wlog[base].d), 32'h100);
        chk("rp_last_addr", 32'(wlog[base+7].a), 11);
        chk("rp_last_data", 32'(wlog[base+7].d), 32'h107);
        chk("rp_pix_cnt", 32'(pix_cnt), 12);

        // Flush: queued pixels vanish, same-cycle pixel becomes pixel 0
        base = wlog.size();
        rd_req = 1'b1; rd_x = 10'd1; rd_y = 10'd0;
        for (int i = 0; i < 3; i++) begin
            wr_valid = 1'b1; wr_data = 12'(12'h0A0 + i); tick();
        end
        frame_start = 1'b1; wr_valid = 1'b1; wr_data = 12'h5A5; tick();
        frame_start = 1'b0; wr_valid = 1'b0;
        chk("fl_pix_cnt0", 32'(pix_cnt), 0);
        tick();
        chk("fl_rd_valid", 32'(rd_valid), 1);
        rd_req = 1'b0;
        repeat (6) tick();
        chk("fl_nwr", wlog.size() - base, 1);
        chk("fl_addr", 32'(wlog[base].a), 0);
        chk("fl_data", 32'(wlog[base].d), 32'h5A5);
        chk("fl_pix_cnt1", 32'(pix_cnt), 1);

        // Completion: full image with a read every 4th cycle
        base = wlog.size(); c0 = n_cmpl;
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        idx = 0; cyc = 0;
        rd_x = 10'd0; rd_y = 10'd0;
        while (idx < 19200 && cyc < 40000) begin
            rd_req   = (cyc % 4 == 3);
            wr_valid = 1'b1;
            wr_data  = 12'(idx);
            acc      = wr_ready;
            tick();
            if (acc) idx++;
            cyc++;
        end
        wr_valid = 1'b0; rd_req = 1'b0;
        repeat (16) tick();
        chk("cp_accepted", idx, 19200);
        chk("cp_nwr", wlog.size() - base, 19200);
        chk("cp_pulses", n_cmpl - c0, 1);
        chk("cp_first_addr", 32'(wlog[base].a), 0);
        chk("cp_last_addr", 32'(wlog[wlog.size()-1].a), 19199);
        chk("cp_last_data", 32'(wlog[wlog.size()-1].d), 32'hAFF);
        chk("cp_pix_cnt", 32'(pix_cnt), 19200);
        base = wlog.size();
        wr_valid = 1'b1; wr_data = 12'h777; repeat (2) tick();
        wr_valid = 1'b0;
        repeat (6) tick();
        chk("cp_discard_nwr", wlog.size() - base, 0);
        chk("cp_discard_pulses", n_cmpl - c0, 1);
        chk("cp_discard_pix_cnt", 32'(pix_cnt), 19200);

        // Reset in the middle of a write
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            wr_valid = (i < 4); wr_data = 12'h321; tick();
            if (spram_wre) seen = 1'b1;
        end
        wr_valid = 1'b0;
        chk("rw_write_seen", 32'(seen), 1);
        #2 rst_n = 1'b0;
        #1;
        chk_reset_values("rw");
        base = wlog.size();
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (6) tick();
        chk("rw_no_write", wlog.size() - base, 0);
        chk("rw_pix_cnt", 32'(pix_cnt), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
